// File: rtl/dram16_bridge.sv
// Bridges 32-bit CPU load/store requests onto a 16-bit halfword-addressed DRAM.
// Word accesses take two DRAM beats. Byte stores are done as a read-modify-write.
module dram16_bridge #(
    parameter int DRAM_AW = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [1:0]         req_size,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    inout  wire  [15:0]        dram_data
);

    typedef enum logic [2:0] {
        IDLE, RD0, RD1, WR0, WR1, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t state, state_nx;

    logic               we_q;
    logic [1:0]         size_q;
    logic [DRAM_AW:0]   addr_q;
    logic [31:0]        wdata_q;
    logic               err_q;
    logic [15:0]        lo_q;
    logic [31:0]        rdata_q;
    logic [DRAM_AW-1:0] dram_addr_q;

    logic               accept;
    logic               req_err;
    logic [DRAM_AW-1:0] hw_q;
    logic [DRAM_AW-1:0] hw1_q;
    logic [15:0]        wr_data;
    logic               unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:DRAM_AW+1];

    assign accept = req_valid && (state == IDLE);
    assign hw_q   = addr_q[DRAM_AW:1];
    assign hw1_q  = hw_q + {{(DRAM_AW-1){1'b0}}, 1'b1};

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = (req_addr[1:0] != 2'b00);
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dram_we  = 1'b0;
        wr_data  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_nx = RESP;
                    else if (!req_we)
                        state_nx = RD0;
                    else if (req_size == 2'b00)
                        state_nx = RMW_RD;
                    else
                        state_nx = WR0;
                end
            end
            RD0:    state_nx = (size_q == 2'b10) ? RD1 : RESP;
            RD1:    state_nx = RESP;
            WR0: begin
                dram_we  = 1'b1;
                wr_data  = wdata_q[15:0];
                state_nx = (size_q == 2'b10) ? WR1 : RESP;
            end
            WR1: begin
                dram_we  = 1'b1;
                wr_data  = wdata_q[31:16];
                state_nx = RESP;
            end
            RMW_RD: state_nx = RMW_WR;
            RMW_WR: begin
                dram_we  = 1'b1;
                // lo_q holds the halfword read in RMW_RD; only the addressed lane changes
                wr_data  = addr_q[0] ? {wdata_q[7:0], lo_q[7:0]} : {lo_q[15:8], wdata_q[7:0]};
                state_nx = RESP;
            end
            RESP:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q        <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            lo_q        <= '0;
            rdata_q     <= '0;
            dram_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        addr_q  <= req_addr[DRAM_AW:0];
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        if (req_err)
                            rdata_q <= '0;
                        else
                            dram_addr_q <= req_addr[DRAM_AW:1];
                    end
                end
                RD0: begin
                    if (size_q == 2'b10) begin
                        lo_q        <= dram_data;
                        dram_addr_q <= hw1_q;
                    end else if (size_q == 2'b01) begin
                        rdata_q <= {16'h0000, dram_data};
                    end else begin
                        rdata_q <= {24'h000000, addr_q[0] ? dram_data[15:8] : dram_data[7:0]};
                    end
                end
                RD1:    rdata_q <= {dram_data, lo_q};
                WR0: begin
                    if (size_q == 2'b10)
                        dram_addr_q <= hw1_q;
                end
                RMW_RD: lo_q <= dram_data;
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign dram_addr  = dram_addr_q;
    assign dram_data  = dram_we ? wr_data : 16'hzzzz;

    logic unused_we_q;
    assign unused_we_q = we_q;

endmodule

// File: tb/tb_dram16_bridge.sv
// Randomised and directed checks of dram16_bridge against a transaction-level
// model of the DRAM contents, response data, latency and write-beat count.
module tb_dram16_bridge;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] dram_addr;
    logic          dram_we;
    wire  [15:0]   dram_data;

    logic [15:0] dram [0:(1<<AW)-1];
    logic [15:0] refm [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    dram16_bridge #(.DRAM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dram_addr(dram_addr), .dram_we(dram_we), .dram_data(dram_data)
    );

    always #5 clk = ~clk;

    // Asynchronous-read DRAM: drives the bus whenever the bridge is not writing
    assign dram_data = dram_we ? 16'hzzzz : dram[dram_addr];
    always @(posedge clk) if (dram_we) dram[dram_addr] <= dram_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (dram_we) we_cnt++;
        if (!dram_we) chk("bus_probe", {16'h0, dram_data}, {16'h0, dram[dram_addr]});
        if (!resp_valid) chk("err_outside_resp", {31'h0, resp_err}, 32'h0);
    end

    function automatic void model(input logic we, input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] wd, output logic e, output logic [31:0] rd,
                                  output int lat, output int wec);
        logic [AW-1:0] hw, hw1;
        hw  = a[AW:1];
        hw1 = hw + 1'b1;
        e   = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
        rd  = 32'h0;
        wec = 0;
        if (e) begin
            lat = 1;
        end else if (!we) begin
            if (sz == 2'd2) begin rd = {refm[hw1], refm[hw]}; lat = 3; end
            else if (sz == 2'd1) begin rd = {16'h0, refm[hw]}; lat = 2; end
            else begin rd = {24'h0, a[0] ? refm[hw][15:8] : refm[hw][7:0]}; lat = 2; end
        end else begin
            if (sz == 2'd2) begin refm[hw] = wd[15:0]; refm[hw1] = wd[31:16]; lat = 3; wec = 2; end
            else if (sz == 2'd1) begin refm[hw] = wd[15:0]; lat = 2; wec = 1; end
            else begin
                if (a[0]) refm[hw][15:8] = wd[7:0];
                else refm[hw][7:0] = wd[7:0];
                lat = 3; wec = 1;
            end
        end
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] got_rd, output int got_lat);
        logic          e;
        logic [31:0]   rd;
        int            lat, wec, n;
        logic [AW-1:0] hw, hw1;
        hw  = a[AW:1];
        hw1 = hw + 1'b1;
        model(we, sz, a, wd, e, rd, lat, wec);
        @(negedge clk);
        chk("ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        we_cnt = 0;
        @(posedge clk); #1;
        // scramble inputs after acceptance: the bridge must use latched copies
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 1;
        while (!resp_valid && n < 8) begin
            chk("ready_busy", {31'h0, req_ready}, 32'h0);
            @(posedge clk); #1;
            n++;
        end
        chk("resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("latency", n, lat);
        chk("resp_err", {31'h0, resp_err}, {31'h0, e});
        if (!we || e) chk("resp_rdata", resp_rdata, rd);
        chk("we_cycles", we_cnt, wec);
        chk("mem_hw", {16'h0, dram[hw]}, {16'h0, refm[hw]});
        chk("mem_hw1", {16'h0, dram[hw1]}, {16'h0, refm[hw1]});
        got_rd  = resp_rdata;
        got_lat = n;
        @(posedge clk); #1;
        chk("pulse_one", {31'h0, resp_valid}, 32'h0);
        chk("rdata_hold", resp_rdata, got_rd);
    endtask

    initial begin
        #500_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   r;
        int            l;
        logic [15:0]   v;
        logic          we;
        logic [1:0]    sz;
        logic [31:0]   a;
        for (int i = 0; i < (1 << AW); i++) begin
            v = 16'($urandom);
            dram[i] = v;
            refm[i] = v;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_addr = '0; req_wdata = '0;
        #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_dram_we", {31'h0, dram_we}, 32'h0);
        chk("rst_dram_addr", {15'h0, dram_addr}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        do_req(1'b1, 2'd2, 32'h0000_0010, 32'h1234_5678, r, l);
        chk("lit_wst_lo", {16'h0, dram[8]}, 32'h5678);
        chk("lit_wst_hi", {16'h0, dram[9]}, 32'h1234);
        chk("lit_wst_lat", l, 3);
        do_req(1'b0, 2'd2, 32'h0000_0010, 32'h0, r, l);
        chk("lit_wld", r, 32'h1234_5678);
        chk("lit_wld_lat", l, 3);
        do_req(1'b0, 2'd1, 32'h0000_0012, 32'h0, r, l);
        chk("lit_hld", r, 32'h0000_1234);
        chk("lit_hld_lat", l, 2);
        do_req(1'b1, 2'd0, 32'h0000_0011, 32'h0000_00AB, r, l);
        chk("lit_bst", {16'h0, dram[8]}, 32'hAB78);
        do_req(1'b0, 2'd0, 32'h0000_0010, 32'h0, r, l);
        chk("lit_bld", r, 32'h0000_0078);
        do_req(1'b0, 2'd2, 32'h0000_0002, 32'h0, r, l);
        chk("lit_mis_rdata", r, 32'h0);
        chk("lit_mis_lat", l, 1);
        do_req(1'b1, 2'd3, 32'h0000_0040, 32'hFFFF_FFFF, r, l);
        chk("lit_sz3_lat", l, 1);
        do_req(1'b1, 2'd2, 32'h0003_FFFC, 32'hCAFE_BABE, r, l);
        chk("lit_top_lo", {16'h0, dram[17'h1FFFE]}, 32'hBABE);
        chk("lit_top_hi", {16'h0, dram[17'h1FFFF]}, 32'hCAFE);
        do_req(1'b0, 2'd2, 32'h0003_FFFE, 32'h0, r, l);
        chk("lit_top_err_rdata", r, 32'h0);
        do_req(1'b0, 2'd1, 32'h0003_FFFE, 32'h0, r, l);
        chk("lit_top_hld", r, 32'h0000_CAFE);
        do_req(1'b1, 2'd1, 32'h0000_0000, 32'h0000_5A5A, r, l);
        do_req(1'b0, 2'd1, 32'hFFFC_0000, 32'h0, r, l);
        chk("lit_wrap_hld", r, 32'h0000_5A5A);

        // reset during the second beat of a word store
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0100; req_wdata = 32'h55AA_33CC;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_wr1", {31'h0, dram_we}, 32'h1);
        rst = 1'b1;
        #1;
        chk("abort_we", {31'h0, dram_we}, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_resp", {31'h0, resp_valid}, 32'h0);
        chk("abort_addr", {15'h0, dram_addr}, 32'h0);
        refm[17'h80] = 16'h33CC;
        @(negedge clk); rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
        end
        chk("abort_ready_after", {31'h0, req_ready}, 32'h1);
        chk("abort_mem_lo", {16'h0, dram[17'h80]}, 32'h33CC);
        chk("abort_mem_hi", {16'h0, dram[17'h81]}, {16'h0, refm[17'h81]});

        for (int k = 0; k < 300; k++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) == 0) a[AW:2] = '1;
            if ($urandom_range(0, 7) == 0) a[AW:2] = '0;
            do_req(we, sz, a, $urandom, r, l);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
